// File: rtl/ram_param.sv
// ram_param: parametrised single-port word RAM with a clear sweep engine.
// Define RAM_PARAM_OUT_REG_EN for a registered read port (1-cycle latency, write-first).
module ram_param #(
    parameter int               WIDTH  = 16,
    parameter int               ADDR_W = 12,
    parameter logic [WIDTH-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  mem [DEPTH];

    assign busy = (state_q == S_CLEAR);

    // Sweep control and write-port arbitration: reset/clear restart, sweep owns the array, else user load
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = address;
        wdata   = in;
        if (reset || clear) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
        end else if (busy) begin
            we      = 1'b1;
            waddr   = ptr_q;
            wdata   = FILL;
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = (&ptr_q) ? S_IDLE : S_CLEAR;
        end else begin
            we = load;
        end
    end

    // State and sweep pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array, single write port shared by sweep and user
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef RAM_PARAM_OUT_REG_EN
    logic [WIDTH-1:0] out_q;

    // Registered read with write-first bypass; blanked during reset and sweep
    always_ff @(posedge clk) begin
        out_q <= (reset || busy) ? '0 : (we ? in : mem[address]);
    end

    assign out = out_q;
`else
    assign out = busy ? '0 : mem[address];
`endif
endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: directed self-checking bench for ram_param (both read-mode builds).
module tb_ram_param;
    localparam logic [15:0] F = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic [2:0]  address = '0;
    logic        load = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] out;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    ram_param #(.WIDTH(16), .ADDR_W(3), .FILL(F)) dut (
        .clk(clk), .reset(reset), .in(in), .address(address),
        .load(load), .clear(clear), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        address = a;
        load = 1'b0;
        clear = 1'b0;
        tick();
        v = out;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_sweep(input string nm, input logic pulse);
        int n = 0;
        while (busy && n < 40) begin
            total++;
            if (out !== 16'h0) begin
                bad++;
                $display("FAIL %s_out_busy: got %h want 0000", nm, out);
            end
            address = 3'(n);
            in = 16'hDEAD;
            load = pulse & ~load;
            tick();
            n++;
        end
        load = 1'b0;
        total++;
        if (n != 8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_len: got %0d edges busy=%b want 8 edges busy=0", nm, n, busy);
        end
    endtask

    task automatic check_all_fill(input string nm);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            total++;
            if (v !== F) begin
                bad++;
                $display("FAIL %s_word%0d: got %h want %h", nm, i, v, F);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b1 || out !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b out=%h want busy=1 out=0000", busy, out);
        end
        reset = 1'b0;
        wait_sweep("reset_sweep", 1'b0);
        check_all_fill("reset_fill");
    endtask

    task automatic test_write;
        logic [15:0] v;
        wr(3'd1, 16'hFFFF);
        wr(3'd2, 16'h00FF);
        address = 3'd3;
        in = 16'h1234;
        load = 1'b0;
        tick();
        rd(3'd1, v);
        total++;
        if (v !== 16'hFFFF) begin bad++; $display("FAIL write_a1: got %h want FFFF", v); end
        rd(3'd2, v);
        total++;
        if (v !== 16'h00FF) begin bad++; $display("FAIL write_a2: got %h want 00FF", v); end
        rd(3'd3, v);
        total++;
        if (v !== F) begin bad++; $display("FAIL write_noload_a3: got %h want A5A5", v); end
    endtask

    task automatic test_boundary;
        logic [15:0] v;
        wr(3'd7, 16'hBEEF);
        wr(3'd0, 16'hCAFE);
        rd(3'd7, v);
        total++;
        if (v !== 16'hBEEF) begin bad++; $display("FAIL bound_a7: got %h want BEEF", v); end
        rd(3'd0, v);
        total++;
        if (v !== 16'hCAFE) begin bad++; $display("FAIL bound_a0: got %h want CAFE", v); end
    endtask

    task automatic test_clear;
        logic [15:0] v;
        address = 3'd4;
        in = 16'h1111;
        load = 1'b1;
        clear = 1'b1;
        tick();
        load = 1'b0;
        clear = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy: got %b want 1", busy); end
        wait_sweep("clear_sweep", 1'b0);
        rd(3'd4, v);
        total++;
        if (v !== F) begin bad++; $display("FAIL clear_a4: got %h want A5A5", v); end
        check_all_fill("clear_fill");
    endtask

    task automatic test_reset_mid;
        wr(3'd6, 16'h0BAD);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        wait_sweep("mid_sweep", 1'b1);
        check_all_fill("mid_fill");
    endtask

    task automatic test_bypass;
        address = 3'd5;
        in = 16'h5555;
        load = 1'b1;
        tick();
        load = 1'b0;
        in = 16'h0000;
        total++;
        if (out !== 16'h5555) begin bad++; $display("FAIL bypass_edge: got %h want 5555", out); end
        tick();
        total++;
        if (out !== 16'h5555) begin bad++; $display("FAIL bypass_hold: got %h want 5555", out); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_boundary();
        test_clear();
        test_reset_mid();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
